// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// Turns single commands from a local valid/ready port into APB transfers
// (SETUP then ACCESS) and returns a one-cycle response pulse per command.
// All outputs come straight from flops.
//
// Parameters:
//    addrWidth      APB address width
//    dataWidth      APB data width
//    TimeoutCycles  ACCESS wait-state limit (timeout build only)
//
// Ports:
//    pclk, rst_n                       clock, synchronous active-low reset
//    cmd_valid, cmd_ready              command handshake
//    cmd_write, cmd_addr, cmd_wdata    command contents (1 = write)
//    rsp_valid, rsp_rdata, rsp_err     completion pulse, read data, error flag
//    psel, penable, paddr, pwrite,
//    pwdata                            APB request side
//    pready, prdata, pslverr           APB slave response
//
// Build option:
//    APB_MASTER_TIMEOUT_EN  when defined, an ACCESS phase that sees
//                           TimeoutCycles cycles of pready=0 is ended with
//                           rsp_err=1; otherwise ACCESS waits forever.
// ---------------------------------------------------------------------------
module apb_master #(
   parameter int addrWidth     = 32,
   parameter int dataWidth     = 32,
   parameter int TimeoutCycles = 16
) (
   input  logic                 pclk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [addrWidth-1:0] cmd_addr,
   input  logic [dataWidth-1:0] cmd_wdata,
   output logic                 rsp_valid,
   output logic [dataWidth-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic [addrWidth-1:0] paddr,
   output logic                 pwrite,
   output logic [dataWidth-1:0] pwdata,
   output logic                 psel,
   output logic                 penable,
   input  logic                 pready,
   input  logic [dataWidth-1:0] prdata,
   input  logic                 pslverr
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic                   cmd_ready_next;
   logic                   psel_next;
   logic                   penable_next;
   logic [addrWidth-1:0]   paddr_next;
   logic                   pwrite_next;
   logic [dataWidth-1:0]   pwdata_next;
   logic                   rsp_valid_next;
   logic [dataWidth-1:0]   rsp_rdata_next;
   logic                   rsp_err_next;
   logic                   timed_out;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CntWidth = $clog2(TimeoutCycles + 1);
   localparam logic [CntWidth-1:0] WaitLimit = CntWidth'(TimeoutCycles - 1);

   logic [CntWidth-1:0] wait_cnt;

   // Wait-state counter: restarts every SETUP and counts each ACCESS cycle
   // the slave stalls. The transfer is abandoned on the stall cycle that
   // brings the count to TimeoutCycles, so the FSM is already back in IDLE
   // when a late pready could show up.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state == SETUP) begin
         wait_cnt <= '0;
      end else if (state == ACCESS && !pready) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign timed_out = (state == ACCESS) && !pready && (wait_cnt == WaitLimit);
`else
   // Without the timeout build the limit has no meaning; this keeps the
   // parameter visibly consumed.
   localparam int unused_timeout = TimeoutCycles;

   assign timed_out = 1'b0;
`endif

   // State and output registers. Reset drops any transfer in flight, so an
   // aborted command never produces a response.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_next;
         cmd_ready <= cmd_ready_next;
         psel      <= psel_next;
         penable   <= penable_next;
         paddr     <= paddr_next;
         pwrite    <= pwrite_next;
         pwdata    <= pwdata_next;
         rsp_valid <= rsp_valid_next;
         rsp_rdata <= rsp_rdata_next;
         rsp_err   <= rsp_err_next;
      end
   end

   // Next-state and next-output decode. The APB request fields are latched
   // once on accept and simply held until completion, when they are zeroed
   // together with psel. Completion lands in IDLE with cmd_ready already set,
   // which is what allows a new command every third cycle.
   always_comb begin
      state_next     = state;
      cmd_ready_next = 1'b0;
      psel_next      = psel;
      penable_next   = penable;
      paddr_next     = paddr;
      pwrite_next    = pwrite;
      pwdata_next    = pwdata;
      rsp_valid_next = 1'b0;
      rsp_rdata_next = '0;
      rsp_err_next   = 1'b0;

      case (state)
         IDLE: begin
            cmd_ready_next = 1'b1;
            psel_next      = 1'b0;
            penable_next   = 1'b0;
            paddr_next     = '0;
            pwrite_next    = 1'b0;
            pwdata_next    = '0;
            if (cmd_valid && cmd_ready) begin
               state_next     = SETUP;
               cmd_ready_next = 1'b0;
               psel_next      = 1'b1;
               paddr_next     = cmd_addr;
               pwrite_next    = cmd_write;
               pwdata_next    = cmd_write ? cmd_wdata : '0;
            end
         end

         SETUP: begin
            state_next   = ACCESS;
            penable_next = 1'b1;
         end

         ACCESS: begin
            if (pready || timed_out) begin
               state_next     = IDLE;
               cmd_ready_next = 1'b1;
               psel_next      = 1'b0;
               penable_next   = 1'b0;
               paddr_next     = '0;
               pwrite_next    = 1'b0;
               pwdata_next    = '0;
               rsp_valid_next = 1'b1;
               rsp_err_next   = pready ? pslverr : 1'b1;
               if (pready && !pslverr && !pwrite) begin
                  rsp_rdata_next = prdata;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
